// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared defaults and request/response types for the 1RW SRAM controller
package sram_ctrl_pkg;
   localparam int ADDR_W_DEF    = 7;
   localparam int DATA_W_DEF    = 46;
   localparam int RSP_DEPTH_DEF = 3;
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;
   typedef struct packed {
      logic [DATA_W_DEF-1:0] rdata;
      logic                  is_write;
   } rsp_t;
endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// sram_ctrl_rsp_fifo: circular response FIFO with occupancy count; pop only when valid_o
module sram_ctrl_rsp_fifo
   import sram_ctrl_pkg::*;
#(
   parameter int  DEPTH = RSP_DEPTH_DEF,
   parameter type T     = rsp_t,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rstb_i,
   input  logic          push_i,
   input  T              data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output T              data_o,
   output logic [CW-1:0] count_o
);
   localparam int PW = $clog2(DEPTH);
   T              mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   // pointer and count bookkeeping; the credit rule upstream makes overflow impossible
   always_ff @(posedge clk_i) begin
      if (!rstb_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i && !pop_i) assert (cnt_q != CW'(DEPTH)) else $error("rsp fifo overflow");
         if (push_i) wr_q <= nxt(wr_q);
         if (pop_i) rd_q <= nxt(rd_q);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end
   // entry storage needs no reset; only the pointers define what is live
   always_ff @(posedge clk_i) if (push_i) mem_q[wr_q] <= data_i;
   assign valid_o = cnt_q != '0;
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/sram_1rw_ctrl.sv
// sram_1rw_ctrl: valid/ready front end for a 1RW SRAM macro; SRAM_CTRL_WRITE_RSP_EN adds write acks
module sram_1rw_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic              CE,
   input  logic              RSTB,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
`ifdef SRAM_CTRL_WRITE_RSP_EN
   output logic              rsp_is_write,
`endif
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_i,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   input  logic [DATA_W-1:0] sram_o
);
   localparam int CW = $clog2(RSP_DEPTH + 1);
`ifdef SRAM_CTRL_WRITE_RSP_EN
   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              is_write;
   } ent_t;
   logic pend_we_q;
`else
   typedef struct packed {
      logic [DATA_W-1:0] rdata;
   } ent_t;
`endif
   logic              fire, pend_d, pend_q, ready_d, ready_q, pop;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] i_q;
   logic [CW-1:0]     cnt, cnt_d;
   ent_t              push_ent, pop_ent;
   assign req_ready = ready_q & RSTB;
   assign fire      = req_valid & req_ready;
   assign sram_csb  = ~fire;
   assign sram_web  = ~(fire & req_we);
   assign sram_a    = fire ? req_addr : a_q;
   assign sram_i    = fire ? req_wdata : i_q;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_rdata = pop_ent.rdata;
`ifdef SRAM_CTRL_WRITE_RSP_EN
   assign pend_d       = fire;
   assign push_ent     = '{rdata: pend_we_q ? '0 : sram_o, is_write: pend_we_q};
   assign sram_oeb     = ~(pend_q & ~pend_we_q);
   assign rsp_is_write = pop_ent.is_write;
   // remembers whether the in-flight slot is a write ack rather than a read
   always_ff @(posedge CE) pend_we_q <= RSTB & req_we;
`else
   assign pend_d   = fire & ~req_we;
   assign push_ent = '{rdata: sram_o};
   assign sram_oeb = ~pend_q;
`endif
   // credit for next cycle counts FIFO entries plus the slot that will be in flight
   always_comb begin
      cnt_d   = cnt + CW'(pend_q) - CW'(pop);
      ready_d = ({1'b0, cnt_d} + (CW + 1)'(pend_d)) < (CW + 1)'(RSP_DEPTH);
   end
   // in-flight slot, registered request credit and pin hold to avoid idle toggling
   always_ff @(posedge CE) begin
      if (!RSTB) begin
         pend_q  <= 1'b0;
         ready_q <= 1'b0;
         a_q     <= '0;
         i_q     <= '0;
      end else begin
         pend_q  <= pend_d;
         ready_q <= ready_d;
         a_q     <= sram_a;
         i_q     <= sram_i;
      end
   end
   sram_ctrl_rsp_fifo #(.DEPTH(RSP_DEPTH), .T(ent_t)) u_fifo (
      .clk_i  (CE),
      .rstb_i (RSTB),
      .push_i (pend_q),
      .data_i (push_ent),
      .pop_i  (pop),
      .valid_o(rsp_valid),
      .data_o (pop_ent),
      .count_o(cnt)
   );
endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// tb_sram_1rw_ctrl: directed scoreboard bench for sram_1rw_ctrl with a behavioural 1RW macro
module tb_sram_1rw_ctrl;
   logic        CE = 1'b0, RSTB = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [6:0]  req_addr = '0;
   logic [45:0] req_wdata = '0;
   logic        req_ready, rsp_valid, sram_csb, sram_web, sram_oeb;
   logic [45:0] rsp_rdata, sram_i;
   logic [6:0]  sram_a;
   wire  [45:0] sram_o;
`ifdef SRAM_CTRL_WRITE_RSP_EN
   logic        rsp_is_write;
`endif
   sram_1rw_ctrl dut (
      .CE(CE), .RSTB(RSTB),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef SRAM_CTRL_WRITE_RSP_EN
      .rsp_is_write(rsp_is_write),
`endif
      .sram_a(sram_a), .sram_i(sram_i), .sram_csb(sram_csb),
      .sram_web(sram_web), .sram_oeb(sram_oeb), .sram_o(sram_o)
   );
   always #5 CE = ~CE;
   logic [45:0] mem [128];
   logic [45:0] o_q;
   always @(posedge CE) if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else o_q <= mem[sram_a];
   end
   assign sram_o = sram_oeb ? 46'bz : o_q;

   int          checks = 0, errors = 0, n_rsp = 0, acc, base;
   logic [46:0] sb [$];
   logic [46:0] mon_e;
   logic [45:0] exp_mem [128];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge CE);
      #1;
   endtask
   task automatic send(input logic we, input logic [6:0] a, input logic [45:0] d);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      for (int k = 0; k < 64 && !req_ready; k++) tick();
      chk("req_ready_wait", req_ready, 1);
      if (req_ready) begin
         if (!we) sb.push_back({1'b0, exp_mem[a]});
`ifdef SRAM_CTRL_WRITE_RSP_EN
         else sb.push_back({1'b1, 46'd0});
`endif
         if (we) exp_mem[a] = d;
      end
      tick();
      req_valid = 1'b0;
   endtask
   task automatic drain();
      for (int k = 0; k < 32 && sb.size() != 0; k++) tick();
      tick();
      chk("drain_empty", sb.size(), 0);
   endtask

   always @(negedge CE) if (RSTB && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL rsp_unexpected: observed rdata %0h expected no response", rsp_rdata);
      end else begin
         mon_e = sb.pop_front();
         n_rsp++;
         chk("rsp_rdata", rsp_rdata, mon_e[45:0]);
`ifdef SRAM_CTRL_WRITE_RSP_EN
         chk("rsp_is_write", rsp_is_write, mon_e[46]);
`endif
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_csb", sram_csb, 1);
      chk("rst_web", sram_web, 1);
      chk("rst_oeb", sram_oeb, 1);
      RSTB = 1'b1;
      #1;
      chk("rst_cycle_after", req_ready, 0);
      tick();
      chk("post_rst_ready", req_ready, 1);
      rsp_ready = 1'b1;
      // write then read addr 5 with latency and OEB window checks
      send(1'b1, 7'd5, 46'h1234);
      drain();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd5;
      #1;
      chk("t1_ready", req_ready, 1);
      chk("t1_csb_fire", sram_csb, 0);
      chk("t1_oeb_fire", sram_oeb, 1);
      sb.push_back({1'b0, exp_mem[5]});
      tick();
      req_valid = 1'b0;
      chk("t1_oeb_n1", sram_oeb, 0);
      chk("t1_valid_n1", rsp_valid, 0);
      tick();
      chk("t1_oeb_n2", sram_oeb, 1);
      chk("t1_valid_n2", rsp_valid, 1);
      chk("t1_rdata_n2", rsp_rdata, 46'h1234);
      drain();
      // write addr 9 then read it on the very next cycle
      req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd9; req_wdata = 46'h2A_BCDE_F012;
      #1;
      chk("t4_csb_wr", sram_csb, 0);
      chk("t4_web_wr", sram_web, 0);
      chk("t4_a_wr", sram_a, 9);
      exp_mem[9] = 46'h2A_BCDE_F012;
`ifdef SRAM_CTRL_WRITE_RSP_EN
      sb.push_back({1'b1, 46'd0});
`endif
      tick();
      send(1'b0, 7'd9, '0);
      #1;
      chk("t4_idle_csb", sram_csb, 1);
      chk("t4_idle_web", sram_web, 1);
      chk("t4_idle_a_hold", sram_a, 9);
      drain();
      // full fill with addr*3, then 128 back-to-back reads
      for (int i = 0; i < 128; i++) send(1'b1, 7'(i), 46'(i * 3));
      drain();
      base = n_rsp;
      for (int i = 0; i < 128; i++) begin
         chk("b2b_ready", req_ready, 1);
         send(1'b0, 7'(i), '0);
         if (i >= 1) chk("b2b_stream", rsp_valid, 1);
      end
      drain();
      chk("b2b_count", n_rsp - base, 128);
      // backpressure: only three reads accepted while rsp_ready is low
      rsp_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(10 + acc);
         if (req_ready) begin
            sb.push_back({1'b0, exp_mem[10 + acc]});
            acc++;
         end
         tick();
      end
      req_valid = 1'b0;
      chk("bp_accepted", acc, 3);
      chk("bp_ready_low", req_ready, 0);
      chk("bp_head_valid", rsp_valid, 1);
      chk("bp_head_data", rsp_rdata, 46'd30);
      rsp_ready = 1'b1;
      drain();
      chk("bp_resume", req_ready, 1);
      // reset with two entries queued and one read in flight
      rsp_ready = 1'b0;
      send(1'b0, 7'd20, '0);
      send(1'b0, 7'd21, '0);
      send(1'b0, 7'd22, '0);
      RSTB = 1'b0;
      tick();
      sb.delete();
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_oeb", sram_oeb, 1);
      tick();
      RSTB = 1'b1;
      rsp_ready = 1'b1;
      tick();
      chk("mid_rst_ready_after", req_ready, 1);
      chk("mid_rst_no_rsp", rsp_valid, 0);
      base = n_rsp;
      send(1'b0, 7'd7, '0);
      drain();
      chk("mid_rst_read", n_rsp - base, 1);
`ifdef SRAM_CTRL_WRITE_RSP_EN
      // write acks interleave in order with read data
      base = n_rsp;
      send(1'b1, 7'd3, 46'h3_3333_3333);
      send(1'b0, 7'd3, '0);
      send(1'b1, 7'd4, 46'h4_4444_4444);
      drain();
      chk("wrsp_count", n_rsp - base, 3);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_1rw_ctrl.md
Name: sram_1rw_ctrl

Overview:
- Initiator-side controller for the single-port 1RW SRAM macros (default geometry 128x46).
- Accepts valid/ready read/write requests and drives the macro pins A/I/CSB/WEB/OEB.
- Captures O one cycle after each read and returns it through a valid/ready response port with a small FIFO and credit-based flow control.
- Sits between client logic and any SRAM1RW-style macro instance.

Parameters:
- ADDR_W, 7, SRAM address width.
- DATA_W, 46, SRAM word width.
- RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 sustains one read per cycle under continuous rsp_ready.

Ports:
- CE  in  1  clock; also drives the macro clock.
- RSTB  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_rdata  out  DATA_W  read data (0 for write responses).
- rsp_is_write  out  1  response is a write ack; only present with SRAM_CTRL_WRITE_RSP_EN.
- sram_a  out  ADDR_W  to macro A.
- sram_i  out  DATA_W  to macro I.
- sram_csb  out  1  to macro CSB, active low.
- sram_web  out  1  to macro WEB, low = write.
- sram_oeb  out  1  to macro OEB, active low.
- sram_o  in  DATA_W  from macro O.

Behaviour:
- Clock and reset: one clock, CE. Reset is synchronous, active-low on RSTB, and sampled on posedge CE.
- Reset values while RSTB=0 and the cycle after:
  - req_ready=0, rsp_valid=0, sram_csb=1, sram_web=1, sram_oeb=1.
  - FIFO count=0, rd_pending=0.
- Request accept:
  - fire = req_valid & req_ready.
  - req_ready = (fifo_count + rd_pending < RSP_DEPTH), registered state only. No combinational path from rsp_ready or req_valid.
  - Without the macro, writes never consume credit, but req_ready is still gated identically, so it is independent of req_we.
- Pin drive, combinational in the fire cycle:
  - sram_csb = ~fire.
  - sram_web = ~(fire & req_we).
  - sram_a = req_addr; sram_i = req_wdata.
  - When not firing: csb=1, web=1; a and i hold their last driven values (registered hold) to cut toggling.
- Read timing:
  - Read accepted in cycle n: the macro samples at the end of n.
  - rd_pending=1 during n+1, with sram_oeb=0 during n+1 only.
  - sram_o is pushed into the FIFO at the end of n+1.
  - rsp_valid is asserted from n+2. Fixed latency 2 with an empty FIFO and rsp_ready=1.
- sram_oeb=1 in all other cycles. sram_o is never sampled while OEB=1 (it may be Z).
- Write: the macro updates at the end of the fire cycle. No response without the macro.
- Read-after-write to the same address in consecutive cycles returns the new data. No forwarding is needed, since the macro has committed the write before the read edge.
- Response FIFO:
  - Circular, pointers wrap modulo RSP_DEPTH.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - Ordering is strict FIFO.
  - Overflow is impossible by the credit rule; assert this in simulation.
- rsp_valid and rsp_rdata are stable until popped.
- Reset mid-operation: the in-flight read and all FIFO contents are discarded, and no response is produced for them.

Optional Feature:
- SRAM_CTRL_WRITE_RSP_EN
- Defined:
  - Writes also consume a credit and push a response entry at the end of n+1, with rdata=0 and rsp_is_write=1.
  - Responses stay in order with reads.
  - sram_oeb stays 1 for write slots.
- Undefined:
  - rsp_is_write port is absent, and only reads produce responses.

Decomposition:
- Package sram_ctrl_pkg holds:
  - req_t struct (we, addr, wdata).
  - rsp_t struct (rdata, is_write).
  - Defaults ADDR_W=7, DATA_W=46, RSP_DEPTH=3.
- One sub-module, sram_ctrl_rsp_fifo: parameterized circular FIFO of rsp_t exposing count.
- The top holds credit, rd_pending and pin logic.

Test Plan:
- Reset then write addr 5 = 46'h1234, read addr 5 -> rsp_rdata=46'h1234 exactly 2 cycles after read fire; sram_oeb low only in the cycle after read fire.
- Back-to-back reads of addrs 0..127 after a full fill with data=addr*3, rsp_ready=1 -> 128 in-order responses, req_ready never drops, one response per cycle.
- rsp_ready=0 with continuous read requests -> exactly 3 accepted, req_ready=0 thereafter; releasing rsp_ready drains 3 in order and resumes acceptance.
- Write addr 9 = A then read addr 9 in the next cycle -> rdata=A; idle cycles show sram_csb=1, sram_web=1.
- Assert RSTB=0 the cycle after a read fire with 2 entries queued -> no rsp_valid after reset, req_ready=1 the cycle after reset release, then a normal read succeeds.
- With SRAM_CTRL_WRITE_RSP_EN: W(3), R(3), W(4) -> responses is_write=1,0,1 in order, read rdata = data written to 3.
